// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage and the data memory.
// Latency: none, wires only.
// Backpressure: the memory holds off completion by delaying ack; req stays high until then.
//   req   : access in flight, held high until ack or abort
//   we    : 1 = store, 0 = load
//   addr  : word-aligned byte address
//   be    : byte enables, bit i covers byte lane i
//   wdata : store data replicated across lanes
//   rdata : load data, valid with ack
//   ack   : single-cycle completion pulse
interface mem_access_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output req, we, addr, be, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: launches data-memory loads/stores, formats load data, drives MEM/WB.
// Latency: 1 cycle for non-memory ops; at least 2 cycles (launch + ack) for a memory access.
// Backpressure: stallM holds the upstream pipeline while an access is outstanding; an access
//   with no ack after TIMEOUT wait cycles is aborted with bus_err.
// Ports: EX/MEM inputs (RegWriteM, MemWriteM, MemtoRegM, strCtrlM, rdM, ALUoutM, r2M),
//   dmem bus (master modport), stallM, MEM/WB outputs (RegWriteW, MemtoRegW, rdW, ALUoutW,
//   ReadDataW), and the single-cycle error pulses misalign_err and bus_err.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      RegWriteM,
    input  logic                      MemWriteM,
    input  logic                      MemtoRegM,
    input  logic [2:0]                strCtrlM,
    input  logic [4:0]                rdM,
    input  logic [31:0]               ALUoutM,
    input  logic [31:0]               r2M,
    mem_access_stage_if.master        dmem,
    output logic                      stallM,
    output logic                      RegWriteW,
    output logic                      MemtoRegW,
    output logic [4:0]                rdW,
    output logic [31:0]               ALUoutW,
    output logic [31:0]               ReadDataW,
    output logic                      misalign_err,
    output logic                      bus_err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic [1:0]  off;
    logic        acc;
    logic        mis;
    logic        cnt_last;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    assign off      = ALUoutM[1:0];
    assign acc      = MemWriteM | MemtoRegM;
    assign cnt_last = (cnt == LAST);

    // Encodings 011/110/111 are illegal; halves need even, words need 4-byte alignment.
    assign mis = (strCtrlM inside {3'b011, 3'b110, 3'b111})
               | ((strCtrlM[1:0] == 2'b01) & off[0])
               | ((strCtrlM == 3'b010) & (off != 2'b00));

    always_comb begin
        be_nxt    = 4'b0000;
        wdata_nxt = 32'h0;
        case (strCtrlM[1:0])
            2'b00: begin
                be_nxt    = 4'b0001 << off;
                wdata_nxt = {4{r2M[7:0]}};
            end
            2'b01: begin
                be_nxt    = 4'b0011 << off;
                wdata_nxt = {2{r2M[15:0]}};
            end
            2'b10: begin
                be_nxt    = 4'b1111;
                wdata_nxt = r2M;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = 8'h0;
        case (off)
            2'd0: ld_byte = dmem.rdata[7:0];
            2'd1: ld_byte = dmem.rdata[15:8];
            2'd2: ld_byte = dmem.rdata[23:16];
            2'd3: ld_byte = dmem.rdata[31:24];
            default: ;
        endcase
        ld_half = off[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
        case (strCtrlM)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = {24'h0, ld_byte};
            3'b101:  ld_fmt = {16'h0, ld_half};
            default: ld_fmt = dmem.rdata;
        endcase
    end

    // These are combinational on the current cycle; rst forces them low so every
    // output reads 0 while reset is held even if EX/MEM still shows an access.
    always_comb begin
        stallM       = 1'b0;
        misalign_err = 1'b0;
        bus_err      = 1'b0;
        if (!rst) begin
            if (state == S_IDLE) begin
                stallM       = acc & ~mis;
                misalign_err = acc & mis;
            end else begin
                stallM  = ~dmem.ack & ~cnt_last;
                bus_err = ~dmem.ack & cnt_last;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            dmem.req   <= 1'b0;
            dmem.we    <= 1'b0;
            dmem.addr  <= 32'h0;
            dmem.be    <= 4'b0000;
            dmem.wdata <= 32'h0;
            RegWriteW  <= 1'b0;
            MemtoRegW  <= 1'b0;
            rdW        <= 5'd0;
            ALUoutW    <= 32'h0;
            ReadDataW  <= 32'h0;
        end else begin
            // MEM/WB takes an all-zero bubble unless an op retires this cycle.
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            rdW       <= 5'd0;
            ALUoutW   <= 32'h0;
            ReadDataW <= 32'h0;
            case (state)
                S_IDLE: begin
                    if (!acc) begin
                        RegWriteW <= RegWriteM;
                        MemtoRegW <= MemtoRegM;
                        rdW       <= rdM;
                        ALUoutW   <= ALUoutM;
                    end else if (!mis) begin
                        dmem.req   <= 1'b1;
                        dmem.we    <= MemWriteM;
                        dmem.addr  <= {ALUoutM[31:2], 2'b00};
                        dmem.be    <= be_nxt;
                        dmem.wdata <= wdata_nxt;
                        cnt        <= '0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dmem.ack) begin
                        // EX/MEM is still held, so its fields describe the access completing now.
                        dmem.req  <= 1'b0;
                        RegWriteW <= RegWriteM;
                        MemtoRegW <= MemtoRegM;
                        rdW       <= rdM;
                        ALUoutW   <= ALUoutM;
                        ReadDataW <= MemWriteM ? 32'h0 : ld_fmt;
                        state     <= S_IDLE;
                    end else if (cnt_last) begin
                        dmem.req <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
